spi_xfer_arbiter: RTL and testbench
===================================

SPI_XFER_ARBITER -- requirements
Module: spi_xfer_arbiter

Interface
REQ-001 Parameter CLK_DIV, default 4: SCK half-period in clk cycles; legal range 2..255.
REQ-002 Parameter CS_SETUP, default 2: clk cycles from CS_n low to the first SCK rising edge.
REQ-003 Parameter CS_HOLD, default 2: clk cycles from the last SCK falling edge to CS_n high.
REQ-004 clk  in  1  sole clock; all logic is rising-edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 req_i  in  2  per-requester transfer request; level, held until the requester sees done_o.
REQ-007 len0_i, len1_i  in  4  per-requester byte count minus one (1..16 bytes).
REQ-008 tx0_i, tx1_i  in  8  next write byte; sampled on the cycle its tx_pop_o bit is high.
REQ-009 tx_pop_o  out  2  one-cycle pulse: the granted requester's byte has been consumed.
REQ-010 rx_data_o  out  8  last received byte; valid while rx_valid_o is nonzero.
REQ-011 rx_valid_o  out  2  one-cycle pulse to the granted requester per received byte.
REQ-012 gnt_o  out  2  one-hot grant; zero when idle.
REQ-013 done_o  out  2  one-cycle pulse when the granted transfer completes.
REQ-014 busy_o  out  1  high in every state except IDLE.
REQ-015 sck_o, mosi_o  out  1 each  SPI clock and data, mode 0 (CPOL=0, CPHA=0), MSB first.
REQ-016 miso_i  in  1  SPI data in; pre-synchronised, so no synchroniser is required.
REQ-017 cs_n_o  out  2  active-low chip select; bit n belongs to requester n.

Function
REQ-018 The FSM SHALL have states IDLE, SETUP, SHIFT, HOLD and GAP.
REQ-019 IDLE with req_i nonzero: the arbiter SHALL set gnt_o and drive the matching cs_n_o low on the next cycle, then enter SETUP.
REQ-020 When both requests are present, the requester not served last SHALL win; after reset requester 0 wins.
REQ-021 The last-served pointer SHALL update only on a grant.
REQ-022 Length SHALL be latched at grant; later changes to len*_i are ignored.
REQ-023 SETUP SHALL last CS_SETUP cycles.
REQ-024 tx_pop_o SHALL pulse on the last SETUP cycle, and on the last cycle of each byte that is not the final byte.
REQ-025 The tx byte SHALL be loaded into the shifter on the cycle after its pop.
REQ-026 SHIFT, per bit: mosi_o is stable while sck_o is low, and miso_i is sampled on the rising edge.
REQ-027 Each bit SHALL take 2*CLK_DIV cycles, so one byte takes 16*CLK_DIV cycles with no gap between bytes.
REQ-028 rx_data_o and the granted bit of rx_valid_o SHALL update on the cycle after each byte's final falling edge.
REQ-029 After byte len+1, the FSM SHALL enter HOLD with sck_o low for CS_HOLD cycles.
REQ-030 GAP SHALL last exactly 1 cycle, with cs_n_o high and gnt_o cleared; done_o pulses in GAP, then the FSM returns to IDLE.
REQ-031 A requester dropping req_i mid-transfer SHALL NOT abort it; the full length completes.
REQ-032 A request still held after done_o SHALL be re-arbitrated normally in IDLE.
REQ-033 The byte counter SHALL be 4 bits; at len=15 (count 15) it terminates, it SHALL NOT wrap.
REQ-034 sck_o SHALL be low and mosi_o SHALL be 0 whenever the FSM is not in SHIFT.

Reset
REQ-035 On rst_n low the FSM SHALL immediately enter IDLE, including mid-transfer.
REQ-036 In reset: cs_n_o=2'b11, sck_o=0, mosi_o=0, and gnt_o, tx_pop_o, rx_valid_o, done_o, busy_o=0.
REQ-037 In reset rx_data_o=8'h00 and the last-served pointer is set to 1, so requester 0 wins first.
REQ-038 No partial byte or done_o pulse SHALL be emitted after reset release.

Structure
REQ-039 A shared package (spi_xfer_pkg) SHALL hold the FSM state enum, the mode-0 CPOL/CPHA constants and the default CLK_DIV, CS_SETUP and CS_HOLD values.
REQ-040 Sub-module spi_byte_shifter SHALL contain the clock divider, the 8-bit shift register and the bit counter, with load/start/byte_done handshake to the FSM.

Verification
REQ-041 req_i=01, len0=0, tx0=A5, miso looped to mosi, CLK_DIV=4 -> exactly 8 SCK pulses, rx_data_o=A5, rx_valid_o=01 once, done_o=01 once, cs_n_o low for 2+64+2 cycles.
REQ-042 req_i=11 held for three consecutive transfers -> gnt_o sequence 01, 10, 01, with a 1-cycle GAP (cs_n_o=11) between each.
REQ-043 len1=15 with tx1 incrementing from 00 -> 16 tx_pop_o pulses, 16 rx_valid_o pulses, 128 SCK pulses, one done_o.
REQ-044 miso_i tied to 1, len0=2 -> rx_data_o=FF three times; mosi_o changes only while sck_o is low.
REQ-045 rst_n asserted during bit 4 of byte 2 -> same-cycle cs_n_o=11, sck_o=0, busy_o=0; after release, no done_o and a fresh req_i=10 is granted normally.
REQ-046 req0 dropped during SETUP -> transfer still completes with len0+1 bytes and done_o=01.

Source files
------------

// File: rtl/spi_xfer_pkg.sv
// Shared definitions for the two-requester SPI transfer arbiter:
// controller state encoding, SPI mode-0 constants, default timing values
// and the round-robin winner selection.
package spi_xfer_pkg;

    // Default timing, all in clk cycles
    localparam int DEF_CLK_DIV  = 4;
    localparam int DEF_CS_SETUP = 2;
    localparam int DEF_CS_HOLD  = 2;

    // SPI mode 0: SCK idles low, data sampled on the rising edge
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    // Controller state codes, kept as plain constants for older tools
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = S_IDLE,
        ST_SETUP = S_SETUP,
        ST_SHIFT = S_SHIFT,
        ST_HOLD  = S_HOLD,
        ST_GAP   = S_GAP
    } xfer_state_e;

    // One-hot winner: a lone request wins outright; with both pending the
    // requester that was not served last wins.
    function automatic logic [1:0] pick_winner(input logic [1:0] req,
                                               input logic       last_served);
        logic [1:0] win;
        win = 2'b00;
        if (req == 2'b11) begin
            win = last_served ? 2'b01 : 2'b10;
        end else begin
            win = req;
        end
        return win;
    endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// One-byte SPI mode-0 engine: SCK divider, 8-bit shift register and bit
// counter. The controller pulses i_load/i_start to begin a byte and sees
// o_byte_done high in the last clk cycle of that byte. Loading a new byte
// in the o_byte_done cycle chains bytes with no idle time between them.
module spi_byte_shifter
    import spi_xfer_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic       i_start,
    input  logic [7:0] i_tx_byte,
    input  logic       i_miso,
    output logic       o_sck,
    output logic       o_mosi,
    output logic       o_byte_done,
    output logic [7:0] o_rx_byte
);

    localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);

    logic       r_active;
    logic       r_sck;
    logic       r_sample;
    logic [7:0] r_div_cnt;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_sr;
    logic       w_half_end;

    assign w_half_end  = r_active && (r_div_cnt == 8'd0);
    assign o_byte_done = w_half_end && r_sck && (r_bit_cnt == 3'd0);

    // The shift register sends from bit 7 and receives into bit 0, so after
    // eight falling edges it holds the received byte; the final sample is
    // merged here so the byte is complete in the o_byte_done cycle.
    assign o_rx_byte = {r_sr[6:0], r_sample};
    assign o_mosi    = r_sr[7];
    assign o_sck     = r_sck;

    // Half-period timing: low half then high half per bit; MISO captured on
    // the rising edge, MOSI advanced on the falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active  <= 1'b0;
            r_sck     <= SPI_CPOL;
            r_sample  <= 1'b0;
            r_div_cnt <= 8'd0;
            r_bit_cnt <= 3'd0;
            r_sr      <= 8'h00;
        end else begin
            if (w_half_end) begin
                r_div_cnt <= DIV_RELOAD;
                if (!r_sck) begin
                    r_sck    <= 1'b1;
                    r_sample <= i_miso;
                end else begin
                    r_sck     <= 1'b0;
                    r_sr      <= {r_sr[6:0], r_sample};
                    r_bit_cnt <= r_bit_cnt - 3'd1;
                    if (r_bit_cnt == 3'd0) begin
                        r_active <= 1'b0;
                    end
                end
            end else if (r_active) begin
                r_div_cnt <= r_div_cnt - 8'd1;
            end
            if (i_load) begin
                r_sr <= i_tx_byte;
            end
            if (i_start) begin
                r_active  <= 1'b1;
                r_sck     <= 1'b0;
                r_div_cnt <= DIV_RELOAD;
                r_bit_cnt <= 3'd7;
            end
        end
    end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// Two-requester SPI master arbiter. Grants one requester at a time,
// drives its chip select, streams len+1 bytes through spi_byte_shifter and
// reports each received byte and transfer completion back to the winner.
//
//  state | meaning
//  IDLE  | no transfer; arbitrate pending requests
//  SETUP | CS_n low, waiting CS_SETUP cycles before the first byte
//  SHIFT | bytes being shifted; chained back to back until byte len+1
//  HOLD  | SCK low, CS_n still low for CS_HOLD cycles
//  GAP   | CS_n high, grant cleared, done pulse to the served requester
module spi_xfer_arbiter
    import spi_xfer_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int CS_SETUP = DEF_CS_SETUP,
    parameter int CS_HOLD  = DEF_CS_HOLD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic [3:0] len0_i,
    input  logic [3:0] len1_i,
    input  logic [7:0] tx0_i,
    input  logic [7:0] tx1_i,
    output logic [1:0] tx_pop_o,
    output logic [7:0] rx_data_o,
    output logic [1:0] rx_valid_o,
    output logic [1:0] gnt_o,
    output logic [1:0] done_o,
    output logic       busy_o,
    output logic       sck_o,
    output logic       mosi_o,
    input  logic       miso_i,
    output logic [1:0] cs_n_o
);

    localparam logic [7:0] SETUP_RELOAD = 8'(CS_SETUP - 1);
    localparam logic [7:0] HOLD_RELOAD  = 8'(CS_HOLD - 1);

    xfer_state_e r_state;
    logic [1:0]  r_gnt;
    logic [1:0]  r_cs_n;
    logic        r_last;
    logic [3:0]  r_len;
    logic [3:0]  r_byte_cnt;
    logic [7:0]  r_phase_cnt;
    logic [1:0]  r_done;
    logic [1:0]  r_rx_valid;
    logic [7:0]  r_rx_data;

    logic [1:0]  w_winner;
    logic        w_in_shift;
    logic        w_setup_end;
    logic        w_byte_done;
    logic        w_last_byte;
    logic        w_pop;
    logic [7:0]  w_tx_byte;
    logic        w_sck;
    logic        w_mosi;
    logic [7:0]  w_rx_byte;

    assign w_winner    = pick_winner(req_i, r_last);
    assign w_in_shift  = (r_state == ST_SHIFT);
    assign w_setup_end = (r_state == ST_SETUP) && (r_phase_cnt == 8'd0);
    assign w_last_byte = (r_byte_cnt == r_len);

    // A byte is popped at the end of SETUP and at the end of every byte
    // except the last; the shifter loads it on the following edge.
    assign w_pop     = w_setup_end || (w_in_shift && w_byte_done && !w_last_byte);
    assign w_tx_byte = r_gnt[1] ? tx1_i : tx0_i;

    assign tx_pop_o   = w_pop ? r_gnt : 2'b00;
    assign gnt_o      = r_gnt;
    assign cs_n_o     = r_cs_n;
    assign done_o     = r_done;
    assign busy_o     = (r_state != ST_IDLE);
    assign rx_valid_o = r_rx_valid;
    assign rx_data_o  = r_rx_data;

    // Shifter outputs are gated so the bus is quiet outside SHIFT
    assign sck_o  = w_in_shift ? w_sck : SPI_CPOL;
    assign mosi_o = w_in_shift && w_mosi;

    spi_byte_shifter #(
        .CLK_DIV(CLK_DIV)
    ) u_shifter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_pop),
        .i_start    (w_pop),
        .i_tx_byte  (w_tx_byte),
        .i_miso     (miso_i),
        .o_sck      (w_sck),
        .o_mosi     (w_mosi),
        .o_byte_done(w_byte_done),
        .o_rx_byte  (w_rx_byte)
    );

    // Transfer sequencing: arbitration, CS timing, byte counting, done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_gnt       <= 2'b00;
            r_cs_n      <= 2'b11;
            r_last      <= 1'b1;
            r_len       <= 4'd0;
            r_byte_cnt  <= 4'd0;
            r_phase_cnt <= 8'd0;
            r_done      <= 2'b00;
        end else begin
            r_done <= 2'b00;
            case (r_state)
                ST_IDLE: begin
                    if (req_i != 2'b00) begin
                        r_gnt       <= w_winner;
                        r_cs_n      <= ~w_winner;
                        r_last      <= w_winner[1];
                        r_len       <= w_winner[1] ? len1_i : len0_i;
                        r_byte_cnt  <= 4'd0;
                        r_phase_cnt <= SETUP_RELOAD;
                        r_state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (r_phase_cnt == 8'd0) begin
                        r_state <= ST_SHIFT;
                    end else begin
                        r_phase_cnt <= r_phase_cnt - 8'd1;
                    end
                end
                ST_SHIFT: begin
                    if (w_byte_done) begin
                        // Terminal compare against the latched length; the
                        // counter never has to pass 15, so it cannot wrap.
                        if (w_last_byte) begin
                            r_phase_cnt <= HOLD_RELOAD;
                            r_state     <= ST_HOLD;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 4'd1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (r_phase_cnt == 8'd0) begin
                        r_done  <= r_gnt;
                        r_gnt   <= 2'b00;
                        r_cs_n  <= 2'b11;
                        r_state <= ST_GAP;
                    end else begin
                        r_phase_cnt <= r_phase_cnt - 8'd1;
                    end
                end
                ST_GAP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_gnt   <= 2'b00;
                    r_cs_n  <= 2'b11;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Received byte is presented the cycle after its final falling edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_valid <= 2'b00;
            r_rx_data  <= 8'h00;
        end else begin
            r_rx_valid <= 2'b00;
            if (w_in_shift && w_byte_done) begin
                r_rx_valid <= r_gnt;
                r_rx_data  <= w_rx_byte;
            end
        end
    end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Self-checking bench for spi_xfer_arbiter: per-scenario tasks, with a
// scoreboard of expected received bytes pushed as stimulus is applied.
module tb_spi_xfer_arbiter;

    logic       clk;
    logic       rst_n;
    logic [1:0] req_i;
    logic [3:0] len0_i;
    logic [3:0] len1_i;
    logic [7:0] tx0_i;
    logic [7:0] tx1_i;
    logic [1:0] tx_pop_o;
    logic [7:0] rx_data_o;
    logic [1:0] rx_valid_o;
    logic [1:0] gnt_o;
    logic [1:0] done_o;
    logic       busy_o;
    logic       sck_o;
    logic       mosi_o;
    logic       miso_i;
    logic [1:0] cs_n_o;

    logic       loop_en;
    logic       miso_force;
    logic [7:0] tx1_base;
    logic [7:0] pop1_total;

    int n_tests;
    int n_fail;

    // Monitor state (written only by the monitor)
    int sck_rise, pop0_cnt, pop1_cnt, rxv_cnt, done0_cnt, done1_cnt, cs_low_cnt, mosi_viol;
    logic       prev_sck;
    logic       prev_mosi;
    logic [1:0] prev_gnt;
    logic [9:0] obs_rx[$];
    logic [1:0] gnt_q[$];
    logic [9:0] exp_rx[$];

    assign miso_i = loop_en ? mosi_o : miso_force;
    assign tx1_i  = tx1_base + pop1_total;

    spi_xfer_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_i),
        .len0_i    (len0_i),
        .len1_i    (len1_i),
        .tx0_i     (tx0_i),
        .tx1_i     (tx1_i),
        .tx_pop_o  (tx_pop_o),
        .rx_data_o (rx_data_o),
        .rx_valid_o(rx_valid_o),
        .gnt_o     (gnt_o),
        .done_o    (done_o),
        .busy_o    (busy_o),
        .sck_o     (sck_o),
        .mosi_o    (mosi_o),
        .miso_i    (miso_i),
        .cs_n_o    (cs_n_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requester 1 source: next byte advances after each pop is consumed
    initial pop1_total = 8'h00;
    always @(posedge clk) begin
        if (tx_pop_o[1]) pop1_total <= pop1_total + 8'd1;
    end

    // Bus and handshake monitor, sampled on the falling clk edge
    initial begin
        sck_rise = 0; pop0_cnt = 0; pop1_cnt = 0; rxv_cnt = 0;
        done0_cnt = 0; done1_cnt = 0; cs_low_cnt = 0; mosi_viol = 0;
        prev_sck = 1'b0; prev_mosi = 1'b0; prev_gnt = 2'b00;
    end
    always @(negedge clk) begin
        if (sck_o && !prev_sck) sck_rise++;
        if (sck_o && (mosi_o !== prev_mosi)) mosi_viol++;
        if (tx_pop_o[0]) pop0_cnt++;
        if (tx_pop_o[1]) pop1_cnt++;
        if (done_o[0]) done0_cnt++;
        if (done_o[1]) done1_cnt++;
        if (cs_n_o != 2'b11) cs_low_cnt++;
        if (rx_valid_o != 2'b00) begin
            rxv_cnt++;
            obs_rx.push_back({rx_valid_o, rx_data_o});
        end
        if (gnt_o != 2'b00 && prev_gnt == 2'b00) gnt_q.push_back(gnt_o);
        prev_sck  = sck_o;
        prev_mosi = mosi_o;
        prev_gnt  = gnt_o;
    end

    task automatic wait_done(input int budget, output logic [1:0] d, output bit ok);
        ok = 1'b0;
        d  = 2'b00;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_o != 2'b00) begin
                d  = done_o;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [7:0] got [8];
        logic [7:0] want [8];
        rst_n = 1'b0; req_i = 2'b00; len0_i = 4'd0; len1_i = 4'd0;
        tx0_i = 8'h00; tx1_base = 8'h00; loop_en = 1'b0; miso_force = 1'b0;
        repeat (3) @(negedge clk);
        got[0] = {6'd0, cs_n_o};     want[0] = 8'h03;
        got[1] = {7'd0, sck_o};      want[1] = 8'h00;
        got[2] = {7'd0, mosi_o};     want[2] = 8'h00;
        got[3] = {6'd0, gnt_o};      want[3] = 8'h00;
        got[4] = {7'd0, busy_o};     want[4] = 8'h00;
        got[5] = {2'd0, tx_pop_o, rx_valid_o, done_o}; want[5] = 8'h00;
        got[6] = rx_data_o;          want[6] = 8'h00;
        got[7] = {6'd0, tx_pop_o};   want[7] = 8'h00;
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (got[i] !== want[i]) begin
                n_fail++;
                $display("FAIL reset_val[%0d]: got %h expected %h", i, got[i], want[i]);
            end
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_loopback();
        int s_sck, s_rxv, s_d0, s_cs, s_p0;
        logic [1:0] d;
        logic [9:0] e, o;
        bit ok;
        s_sck = sck_rise; s_rxv = rxv_cnt; s_d0 = done0_cnt; s_cs = cs_low_cnt; s_p0 = pop0_cnt;
        loop_en = 1'b1; len0_i = 4'd0; tx0_i = 8'hA5;
        exp_rx.push_back({2'b01, 8'hA5});
        req_i = 2'b01;
        @(negedge clk);
        n_tests++;
        if ({gnt_o, cs_n_o, busy_o} !== {2'b01, 2'b10, 1'b1}) begin
            n_fail++;
            $display("FAIL loop_grant: got gnt=%b cs=%b busy=%b expected 01 10 1", gnt_o, cs_n_o, busy_o);
        end
        wait_done(300, d, ok);
        req_i = 2'b00;
        n_tests++;
        if (!ok || d !== 2'b01) begin
            n_fail++;
            $display("FAIL loop_done: got %b ok=%0d expected 01", d, ok);
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (sck_rise - s_sck != 8) begin n_fail++; $display("FAIL loop_sck: got %0d expected 8", sck_rise - s_sck); end
        n_tests++;
        if (rxv_cnt - s_rxv != 1) begin n_fail++; $display("FAIL loop_rxv: got %0d expected 1", rxv_cnt - s_rxv); end
        n_tests++;
        if (done0_cnt - s_d0 != 1) begin n_fail++; $display("FAIL loop_done_cnt: got %0d expected 1", done0_cnt - s_d0); end
        n_tests++;
        if (cs_low_cnt - s_cs != 68) begin n_fail++; $display("FAIL loop_cs_low: got %0d expected 68", cs_low_cnt - s_cs); end
        n_tests++;
        if (pop0_cnt - s_p0 != 1) begin n_fail++; $display("FAIL loop_pop: got %0d expected 1", pop0_cnt - s_p0); end
        while (exp_rx.size() > 0) begin
            e = exp_rx.pop_front();
            o = 10'h3FF;
            if (obs_rx.size() > 0) o = obs_rx.pop_front();
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL loop_rx: got %h expected %h", o, e); end
        end
        n_tests++;
        if (obs_rx.size() != 0) begin n_fail++; $display("FAIL loop_rx_extra: got %0d extra expected 0", obs_rx.size()); end
        obs_rx.delete();
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g [3];
        logic [1:0] d, g;
        logic [9:0] e, o;
        bit ok;
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        gnt_q.delete(); obs_rx.delete();
        loop_en = 1'b0; miso_force = 1'b0; len0_i = 4'd0; len1_i = 4'd0;
        for (int k = 0; k < 3; k++) exp_rx.push_back({exp_g[k], 8'h00});
        req_i = 2'b11;
        for (int k = 0; k < 3; k++) begin
            wait_done(300, d, ok);
            if (k == 2) req_i = 2'b00;
            n_tests++;
            if (!ok || d !== exp_g[k]) begin
                n_fail++;
                $display("FAIL rr_done[%0d]: got %b ok=%0d expected %b", k, d, ok, exp_g[k]);
            end
            n_tests++;
            if ({cs_n_o, gnt_o} !== 4'b1100) begin
                n_fail++;
                $display("FAIL rr_gap[%0d]: got cs=%b gnt=%b expected 11 00", k, cs_n_o, gnt_o);
            end
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (gnt_q.size() != 3) begin n_fail++; $display("FAIL rr_gnt_count: got %0d expected 3", gnt_q.size()); end
        for (int k = 0; k < 3; k++) begin
            g = 2'b00;
            if (gnt_q.size() > 0) g = gnt_q.pop_front();
            n_tests++;
            if (g !== exp_g[k]) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b expected %b", k, g, exp_g[k]); end
        end
        while (exp_rx.size() > 0) begin
            e = exp_rx.pop_front();
            o = 10'h3FF;
            if (obs_rx.size() > 0) o = obs_rx.pop_front();
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL rr_rx: got %h expected %h", o, e); end
        end
        obs_rx.delete();
    endtask

    task automatic test_max_len();
        int s_sck, s_rxv, s_d1, s_p1;
        logic [1:0] d;
        logic [9:0] e, o;
        bit ok;
        s_sck = sck_rise; s_rxv = rxv_cnt; s_d1 = done1_cnt; s_p1 = pop1_cnt;
        loop_en = 1'b1; len1_i = 4'd15;
        tx1_base = 8'h00 - pop1_total;
        for (int k = 0; k < 16; k++) exp_rx.push_back({2'b10, 8'(k)});
        req_i = 2'b10;
        @(negedge clk);
        len1_i = 4'd0;
        wait_done(2500, d, ok);
        req_i = 2'b00;
        n_tests++;
        if (!ok || d !== 2'b10) begin n_fail++; $display("FAIL max_done: got %b ok=%0d expected 10", d, ok); end
        repeat (3) @(negedge clk);
        n_tests++;
        if (pop1_cnt - s_p1 != 16) begin n_fail++; $display("FAIL max_pop: got %0d expected 16", pop1_cnt - s_p1); end
        n_tests++;
        if (rxv_cnt - s_rxv != 16) begin n_fail++; $display("FAIL max_rxv: got %0d expected 16", rxv_cnt - s_rxv); end
        n_tests++;
        if (sck_rise - s_sck != 128) begin n_fail++; $display("FAIL max_sck: got %0d expected 128", sck_rise - s_sck); end
        n_tests++;
        if (done1_cnt - s_d1 != 1) begin n_fail++; $display("FAIL max_done_cnt: got %0d expected 1", done1_cnt - s_d1); end
        while (exp_rx.size() > 0) begin
            e = exp_rx.pop_front();
            o = 10'h3FF;
            if (obs_rx.size() > 0) o = obs_rx.pop_front();
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL max_rx: got %h expected %h", o, e); end
        end
        obs_rx.delete();
    endtask

    task automatic test_miso_ones();
        int s_mv, s_rxv;
        logic [1:0] d;
        logic [9:0] e, o;
        bit ok;
        s_mv = mosi_viol; s_rxv = rxv_cnt;
        loop_en = 1'b0; miso_force = 1'b1; len0_i = 4'd2; tx0_i = 8'h3C;
        for (int k = 0; k < 3; k++) exp_rx.push_back({2'b01, 8'hFF});
        req_i = 2'b01;
        wait_done(800, d, ok);
        req_i = 2'b00;
        n_tests++;
        if (!ok || d !== 2'b01) begin n_fail++; $display("FAIL ones_done: got %b ok=%0d expected 01", d, ok); end
        repeat (3) @(negedge clk);
        n_tests++;
        if (mosi_viol - s_mv != 0) begin n_fail++; $display("FAIL ones_mosi_stable: got %0d changes expected 0", mosi_viol - s_mv); end
        n_tests++;
        if (rxv_cnt - s_rxv != 3) begin n_fail++; $display("FAIL ones_rxv: got %0d expected 3", rxv_cnt - s_rxv); end
        while (exp_rx.size() > 0) begin
            e = exp_rx.pop_front();
            o = 10'h3FF;
            if (obs_rx.size() > 0) o = obs_rx.pop_front();
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL ones_rx: got %h expected %h", o, e); end
        end
        miso_force = 1'b0;
        obs_rx.delete();
    endtask

    task automatic test_drop_req();
        int s_rxv, s_p0;
        logic [1:0] d;
        logic [9:0] e, o;
        bit ok;
        s_rxv = rxv_cnt; s_p0 = pop0_cnt;
        loop_en = 1'b1; len0_i = 4'd1; tx0_i = 8'h5A;
        for (int k = 0; k < 2; k++) exp_rx.push_back({2'b01, 8'h5A});
        req_i = 2'b01;
        @(negedge clk);
        n_tests++;
        if (gnt_o !== 2'b01) begin n_fail++; $display("FAIL drop_grant: got %b expected 01", gnt_o); end
        req_i = 2'b00;
        wait_done(600, d, ok);
        n_tests++;
        if (!ok || d !== 2'b01) begin n_fail++; $display("FAIL drop_done: got %b ok=%0d expected 01", d, ok); end
        repeat (3) @(negedge clk);
        n_tests++;
        if (rxv_cnt - s_rxv != 2) begin n_fail++; $display("FAIL drop_rxv: got %0d expected 2", rxv_cnt - s_rxv); end
        n_tests++;
        if (pop0_cnt - s_p0 != 2) begin n_fail++; $display("FAIL drop_pop: got %0d expected 2", pop0_cnt - s_p0); end
        while (exp_rx.size() > 0) begin
            e = exp_rx.pop_front();
            o = 10'h3FF;
            if (obs_rx.size() > 0) o = obs_rx.pop_front();
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL drop_rx: got %h expected %h", o, e); end
        end
        obs_rx.delete();
    endtask

    task automatic test_reset_mid();
        int s_p0, s_d0, s_d1, s_rxv, s_sck;
        logic [1:0] d;
        logic [9:0] e, o;
        bit ok;
        bit reached;
        s_p0 = pop0_cnt; s_d0 = done0_cnt; s_d1 = done1_cnt; s_rxv = rxv_cnt;
        loop_en = 1'b1; len0_i = 4'd3; tx0_i = 8'hC3;
        exp_rx.push_back({2'b01, 8'hC3});
        req_i = 2'b01;
        reached = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (pop0_cnt - s_p0 >= 2) begin
                reached = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!reached) begin n_fail++; $display("FAIL rmid_byte2: got %0d pops expected 2", pop0_cnt - s_p0); end
        // Move into the fourth bit of byte 2 (3 full bits plus half a bit)
        repeat (1 + 3 * 8 + 4) @(negedge clk);
        n_tests++;
        if (busy_o !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_pre: got %b expected 1", busy_o); end
        #2;
        rst_n = 1'b0;
        req_i = 2'b00;
        #1;
        n_tests++;
        if ({cs_n_o, sck_o, busy_o, gnt_o} !== 6'b110000) begin
            n_fail++;
            $display("FAIL rmid_async: got cs=%b sck=%b busy=%b gnt=%b expected 11 0 0 00", cs_n_o, sck_o, busy_o, gnt_o);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        s_sck = sck_rise;
        repeat (60) @(negedge clk);
        n_tests++;
        if (done0_cnt - s_d0 != 0) begin n_fail++; $display("FAIL rmid_no_done: got %0d expected 0", done0_cnt - s_d0); end
        n_tests++;
        if (rxv_cnt - s_rxv != 1) begin n_fail++; $display("FAIL rmid_rxv: got %0d expected 1", rxv_cnt - s_rxv); end
        n_tests++;
        if (sck_rise - s_sck != 0) begin n_fail++; $display("FAIL rmid_no_sck: got %0d expected 0", sck_rise - s_sck); end
        len1_i = 4'd0;
        tx1_base = 8'h77 - pop1_total;
        exp_rx.push_back({2'b10, 8'h77});
        req_i = 2'b10;
        @(negedge clk);
        n_tests++;
        if (gnt_o !== 2'b10) begin n_fail++; $display("FAIL rmid_regrant: got %b expected 10", gnt_o); end
        wait_done(300, d, ok);
        req_i = 2'b00;
        n_tests++;
        if (!ok || d !== 2'b10) begin n_fail++; $display("FAIL rmid_done: got %b ok=%0d expected 10", d, ok); end
        repeat (3) @(negedge clk);
        n_tests++;
        if (done1_cnt - s_d1 != 1) begin n_fail++; $display("FAIL rmid_done_cnt: got %0d expected 1", done1_cnt - s_d1); end
        while (exp_rx.size() > 0) begin
            e = exp_rx.pop_front();
            o = 10'h3FF;
            if (obs_rx.size() > 0) o = obs_rx.pop_front();
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL rmid_rx: got %h expected %h", o, e); end
        end
        n_tests++;
        if (obs_rx.size() != 0) begin n_fail++; $display("FAIL rmid_rx_extra: got %0d extra expected 0", obs_rx.size()); end
        obs_rx.delete();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_loopback();
        test_round_robin();
        test_max_len();
        test_miso_ones();
        test_drop_req();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
